// File: rtl/rvfi_trace_scheduler.sv
// -----------------------------------------------------------------------------
// rvfi_trace_scheduler
//
// Buffers RVFI retirement records in a first-word-fall-through FIFO so that a
// co-simulation checker can consume them at its own pace. It tracks records
// lost to overflow and stops accepting new records once the halting
// instruction has been recorded. After that, the buffer drains and done is
// raised.
//
// Optional feature (compile-time macro RVFI_SCHED_ORDER_CHECK_EN):
//   Each record that is pushed or dropped in RUN has its rvfi_order compared
//   with an expected sequence number. A mismatch sets the sticky order_err
//   flag, and the expected value then resynchronises to rvfi_order+1.
//   When the macro is not defined, order_err is tied low.
//
// Parameters
//   DEPTH   FIFO entries (power of two, 2..64)
//   DROP_W  width of the saturating dropped-record counter
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   rvfi_*                      retirement record input (valid + fields)
//   flush                       empties the buffer and returns to RUN
//   out_valid / out_ready       head-record handshake. A pop happens at a
//                               rising edge where both are high; out_* carry
//                               the head record whenever out_valid is high.
//   out_order .. out_trap       head record fields (combinational from storage)
//   count                       entries currently held
//   overflow, drop_cnt          sticky drop flag, saturating drop counter
//   order_err                   sticky sequence-number mismatch flag
//   done                        registered; high while in HALTED
//   dbg_state                   FSM state (0 RUN, 1 DRAIN, 2 HALTED)
// -----------------------------------------------------------------------------
module rvfi_trace_scheduler #(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rvfi_valid,
    input  logic [63:0]                rvfi_order,
    input  logic [31:0]                rvfi_pc_rdata,
    input  logic [31:0]                rvfi_insn,
    input  logic [31:0]                rvfi_rd_wdata,
    input  logic [4:0]                 rvfi_rd_addr,
    input  logic                       rvfi_trap,
    input  logic                       rvfi_halt,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_order,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_insn,
    output logic [4:0]                 out_rd_addr,
    output logic [31:0]                out_rd_wdata,
    output logic                       out_trap,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic                       order_err,
    output logic                       done,
    output logic [1:0]                 dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic        trap;
    } rec_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    rec_t              mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic full;
    logic in_run;
    logic pop;
    logic push;
    logic drop;
    logic seen;
    rec_t in_rec;

    assign in_rec = '{order:    rvfi_order,
                      pc:       rvfi_pc_rdata,
                      insn:     rvfi_insn,
                      rd_addr:  rvfi_rd_addr,
                      rd_wdata: rvfi_rd_wdata,
                      trap:     rvfi_trap};

    assign full   = (count_q == CW'(DEPTH));
    assign in_run = (state_q == ST_RUN);
    assign pop    = (count_q != '0) && out_ready;
    // A push into a full FIFO is allowed when the head leaves at the same edge.
    // Records that arrive during a flush are discarded, not counted as drops.
    assign push   = rvfi_valid && in_run && !flush && (!full || pop);
    assign drop   = rvfi_valid && in_run && !flush && full && !pop;
    assign seen   = push || drop;

    // ---------------- datapath next-state ----------------
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + DROP_W'(1);
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            // A halting record moves the FSM to DRAIN even if it was dropped.
            ST_RUN:    if (seen && rvfi_halt) state_d = ST_DRAIN;
            // No pushes happen in DRAIN, so count_d here reflects only pops.
            ST_DRAIN:  if (count_d == '0)     state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
        if (flush) begin
            state_d = ST_RUN;
        end
    end

    // ---------------- FSM: output logic ----------------
    always_comb begin
        done_d    = (state_d == ST_HALTED);
        dbg_state = state_q;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage has no reset; its contents are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_rec;
        end
    end

`ifdef RVFI_SCHED_ORDER_CHECK_EN
    logic [63:0] exp_order_q, exp_order_d;
    logic        order_err_q, order_err_d;

    always_comb begin
        exp_order_d = exp_order_q;
        order_err_d = order_err_q;
        if (seen) begin
            if (rvfi_order != exp_order_q) begin
                order_err_d = 1'b1;
            end
            // Resync on every record so one gap reports once, not forever.
            exp_order_d = rvfi_order + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_order_q <= '0;
            order_err_q <= 1'b0;
        end else begin
            exp_order_q <= exp_order_d;
            order_err_q <= order_err_d;
        end
    end

    assign order_err = order_err_q;
`else
    assign order_err = 1'b0;
`endif

    // ---------------- outputs ----------------
    assign out_valid    = (count_q != '0);
    assign out_order    = mem_q[rd_ptr_q].order;
    assign out_pc       = mem_q[rd_ptr_q].pc;
    assign out_insn     = mem_q[rd_ptr_q].insn;
    assign out_rd_addr  = mem_q[rd_ptr_q].rd_addr;
    assign out_rd_wdata = mem_q[rd_ptr_q].rd_wdata;
    assign out_trap     = mem_q[rd_ptr_q].trap;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign drop_cnt     = drop_cnt_q;
    assign done         = done_q;

endmodule

// File: tb/tb_rvfi_trace_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rvfi_trace_scheduler
//
// Drives random and directed RVFI traffic into rvfi_trace_scheduler (DEPTH=8,
// DROP_W=4 so counter saturation is reachable). A queue-based reference model
// holds the records that should be buffered. A negedge monitor compares the
// DUT head record and status outputs against this model, and it pops the
// expected queue whenever a handshake is due at the next edge.
// -----------------------------------------------------------------------------
module tb_rvfi_trace_scheduler;

  localparam int DEPTH    = 8;
  localparam int DROP_W   = 4;
  localparam int DROP_MAX = (1 << DROP_W) - 1;
  localparam int REC_W    = 166;
  localparam int M_RUN    = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_HALTED = 2;

  // ---------------- clock / reset / DUT signals ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rvfi_valid = 1'b0;
  logic [63:0] rvfi_order = '0;
  logic [31:0] rvfi_pc_rdata = '0;
  logic [31:0] rvfi_insn = '0;
  logic [31:0] rvfi_rd_wdata = '0;
  logic [4:0]  rvfi_rd_addr = '0;
  logic        rvfi_trap = 1'b0;
  logic        rvfi_halt = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [63:0] out_order;
  logic [31:0] out_pc;
  logic [31:0] out_insn;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_rd_wdata;
  logic        out_trap;
  logic [$clog2(DEPTH):0] count;
  logic        overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic        order_err;
  logic        done;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  rvfi_trace_scheduler #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .rvfi_valid   (rvfi_valid),
    .rvfi_order   (rvfi_order),
    .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_insn    (rvfi_insn),
    .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_rd_addr (rvfi_rd_addr),
    .rvfi_trap    (rvfi_trap),
    .rvfi_halt    (rvfi_halt),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_order    (out_order),
    .out_pc       (out_pc),
    .out_insn     (out_insn),
    .out_rd_addr  (out_rd_addr),
    .out_rd_wdata (out_rd_wdata),
    .out_trap     (out_trap),
    .count        (count),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .order_err    (order_err),
    .done         (done),
    .dbg_state    (dbg_state)
  );

  // ---------------- reference model state ----------------
  logic [REC_W-1:0] exp_q[$];
  int          m_state = M_RUN;
  bit          m_over  = 1'b0;
  int          m_drop  = 0;
  bit          m_oerr  = 1'b0;
  logic [63:0] m_exp_ord = '0;
  bit          mon_en  = 1'b0;
  int          n_cmp   = 0;
  int          n_err   = 0;
  logic [63:0] ord     = '0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 192'(out_valid), 192'(exp_q.size() != 0));
      chk("count", 192'(count), 192'(exp_q.size()));
      chk("overflow", 192'(overflow), 192'(m_over));
      chk("drop_cnt", 192'(drop_cnt), 192'(m_drop));
      chk("done", 192'(done), 192'(m_state == M_HALTED));
      chk("order_err", 192'(order_err), 192'(m_oerr));
      if (exp_q.size() != 0) begin
        chk("head", 192'({out_order, out_pc, out_insn, out_rd_addr, out_rd_wdata, out_trap}),
            192'(exp_q[0]));
        if (out_ready && !flush && !reset) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Presents one cycle of stimulus, waits for the edge, then advances the
  // model by the effect that edge should have had.
  task automatic step(input bit rst, input bit fl, input bit v, input bit h,
                      input bit rdy, input logic [63:0] o);
    logic [31:0] r_pc, r_insn, r_wd, r_misc;
    logic [REC_W-1:0] rec;
    bit pop_due, accept;
    r_pc   = $urandom;
    r_insn = $urandom;
    r_wd   = $urandom;
    r_misc = $urandom;
    reset         = rst;
    flush         = fl;
    rvfi_valid    = v;
    rvfi_halt     = h;
    out_ready     = rdy;
    rvfi_order    = o;
    rvfi_pc_rdata = r_pc;
    rvfi_insn     = r_insn;
    rvfi_rd_wdata = r_wd;
    rvfi_rd_addr  = r_misc[4:0];
    rvfi_trap     = r_misc[5];
    rec = {o, r_pc, r_insn, r_misc[4:0], r_wd, r_misc[5]};
    pop_due = !rst && !fl && (exp_q.size() != 0) && rdy;
    accept  = !rst && !fl && v && (m_state == M_RUN) && ((exp_q.size() < DEPTH) || pop_due);
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      m_state = M_RUN;
      m_over = 1'b0;
      m_drop = 0;
      m_oerr = 1'b0;
      m_exp_ord = '0;
    end else if (fl) begin
      exp_q.delete();
      m_state = M_RUN;
    end else if (v && m_state == M_RUN) begin
      if (accept) exp_q.push_back(rec);
      else begin
        m_over = 1'b1;
        if (m_drop < DROP_MAX) m_drop++;
      end
`ifdef RVFI_SCHED_ORDER_CHECK_EN
      if (o != m_exp_ord) m_oerr = 1'b1;
      m_exp_ord = o + 64'd1;
`endif
      if (h) m_state = M_DRAIN;
    end else if (m_state == M_DRAIN && exp_q.size() == 0) begin
      m_state = M_HALTED;
    end
  endtask

  task automatic send(input bit rdy, input bit h);
    step(1'b0, 1'b0, 1'b1, h, rdy, ord);
    ord = ord + 64'd1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, rdy, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);
    mon_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0);

    // Three in-order records streamed straight through.
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
    idle(3, 1'b1);

    // Fill past full with no consumer, then push and pop together on a full buffer.
    for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    idle(10, 1'b1);

    // Enough drops to saturate the narrow drop counter.
    for (int i = 0; i < 25; i++) send(1'b0, 1'b0);
    idle(10, 1'b1);

    // Halt with two records already buffered; later records are ignored.
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ord + 64'd100);
    idle(6, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    idle(2, 1'b1);

    // Sequence gap: N, N+1, N+3, N+4.
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    ord = ord + 64'd1;
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    idle(3, 1'b1);

    // Reset with five entries held and overflow set.
    for (int i = 0; i < 10; i++) send(1'b0, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, ord);
    ord = '0;
    idle(2, 1'b1);

    // Random traffic with occasional halts, flushes and sequence gaps.
    for (int i = 0; i < 800; i++) begin
      bit fl, v, h, rdy;
      fl  = ($urandom_range(0, 99) < 3);
      v   = ($urandom_range(0, 99) < 70);
      h   = ($urandom_range(0, 99) < 3);
      rdy = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 99) < 4) ord = ord + 64'd1;
      step(1'b0, fl, v, h, rdy, ord);
      if (v) ord = ord + 64'd1;
    end
    idle(12, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
